// File: rtl/shift_sub_divider.sv
// Iterative restoring divider producing {remainder, quotient} after 32 steps.
// Define DIVIDER_SIGNED_EN to also accept the signed start code DIV.
module shift_sub_divider #(
  parameter logic [5:0] DIVU = 6'b011011,
  parameter logic [5:0] DIV  = 6'b011010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        divZero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rem_p0;
  logic [31:0] quot_p0;
  logic [31:0] dvsr_p0;
  logic [31:0] dvnd_p0;
  logic [4:0]  step_p0;
  logic        zero_p0;
  logic        start_u, start_s, start;
  logic        finish;
  logic [63:0] step_res;
  logic [31:0] rem_fin, quot_fin;
  logic [63:0] result;

  // The shifted partial remainder is 33 bits so the compare/subtract cannot wrap.
  function automatic logic [63:0] restore_step(input logic [31:0] rem,
                                               input logic [31:0] quot,
                                               input logic [31:0] dvsr);
    logic [32:0] sh;
    logic [31:0] q;
    sh = {rem, quot[31]};
    q  = {quot[30:0], 1'b0};
    if (sh >= {1'b0, dvsr}) begin
      sh   = sh - {1'b0, dvsr};
      q[0] = 1'b1;
    end
    return {sh[31:0], q};
  endfunction

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_p0, neg_r_p0;

  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign start_s = (state == IDLE) && (Signal == DIV) && (Signal != DIVU);
`else
  // DIV is decoded but masked off: the unsigned build has no signed start.
  assign start_s = (Signal == DIV) & 1'b0;
`endif

  assign start_u = (state == IDLE) && (Signal == DIVU);
  assign start   = start_u | start_s;
  assign finish  = (state == RUN) && (zero_p0 || (step_p0 == 5'd31));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) && !zero_p0;
  assign done = (state == DONE);

  always_comb begin
    step_res = restore_step(rem_p0, quot_p0, dvsr_p0);
    rem_fin  = step_res[63:32];
    quot_fin = step_res[31:0];
`ifdef DIVIDER_SIGNED_EN
    rem_fin  = cond_neg(rem_fin, neg_r_p0);
    quot_fin = cond_neg(quot_fin, neg_q_p0);
`endif
    if (zero_p0) result = {dvnd_p0, 32'hFFFF_FFFF};
    else         result = {rem_fin, quot_fin};
  end

  // Control and the visible result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dataOut <= '0;
      divZero <= 1'b0;
      step_p0 <= '0;
      zero_p0 <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        divZero <= 1'b0;
        step_p0 <= '0;
        zero_p0 <= (dataB == 32'd0);
`ifdef DIVIDER_SIGNED_EN
        neg_q_p0 <= start_s && (dataA[31] ^ dataB[31]);
        neg_r_p0 <= start_s && dataA[31];
`endif
      end else if (state == RUN) begin
        step_p0 <= step_p0 + 5'd1;
      end
      if (finish) begin
        dataOut <= result;
        divZero <= zero_p0;
      end
    end
  end

  // Iteration datapath; contents are don't-care outside RUN
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0  <= '0;
      dvnd_p0 <= dataA;
`ifdef DIVIDER_SIGNED_EN
      quot_p0 <= start_s ? abs_mag(dataA) : dataA;
      dvsr_p0 <= start_s ? abs_mag(dataB) : dataB;
`else
      quot_p0 <= dataA;
      dvsr_p0 <= dataB;
`endif
    end else if (state == RUN) begin
      rem_p0  <= step_res[63:32];
      quot_p0 <= step_res[31:0];
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider (unsigned, zero divisor,
// reset, busy/restart behaviour, and the optional signed build).
module tb_shift_sub_divider;

  localparam logic [5:0] DIVU_C = 6'b011011;
  localparam logic [5:0] DIV_C  = 6'b011010;
  localparam logic [5:0] NOP_C  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = NOP_C;
  logic [63:0] dataOut;
  logic        busy, done, divZero;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sub_divider dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .dataOut(dataOut), .busy(busy), .done(done), .divZero(divZero)
  );

  always #5 clk = ~clk;

  // Issue a start at edge E0, then wait (bounded) for done; returns the
  // number of edges after E0 at which done was seen (-1 on timeout).
  task automatic do_div(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output logic dz);
    @(negedge clk);
    Signal = sig; dataA = a; dataB = b;
    @(posedge clk); #1;
    Signal = NOP_C;
    lat = -1; res = '0; dz = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i; res = dataOut; dz = divZero;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dataOut !== 64'd0) begin n_bad++; $display("FAIL reset_dataOut: got %h need 0", dataOut); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b need 0", done); end
    n_cmp++; if (divZero !== 1'b0) begin n_bad++; $display("FAIL reset_divZero: got %b need 0", divZero); end
    reset = 1'b0;
  endtask

  task automatic test_div_zero;
    @(negedge clk);
    Signal = DIVU_C; dataA = 32'd123; dataB = 32'd0;
    @(posedge clk); #1;
    Signal = NOP_C;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy_e0: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dz_done_e0: got %b need 0", done); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dz_done_e1: got %b need 1", done); end
    n_cmp++; if (divZero !== 1'b1) begin n_bad++; $display("FAIL dz_flag_e1: got %b need 1", divZero); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy_e1: got %b need 0", busy); end
    n_cmp++; if (dataOut !== {32'd123, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL dz_dataOut: got %h need %h", dataOut, {32'd123, 32'hFFFF_FFFF}); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dz_done_e2: got %b need 0", done); end
    n_cmp++; if (divZero !== 1'b1) begin n_bad++; $display("FAIL dz_flag_hold: got %b need 1", divZero); end
  endtask

  task automatic test_unsigned;
    logic [63:0] r; int lat; logic dz;
    @(negedge clk);
    Signal = DIVU_C; dataA = 32'd100; dataB = 32'd7;
    @(posedge clk); #1;
    Signal = NOP_C;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL u_busy_e0: got %b need 1", busy); end
    n_cmp++; if (divZero !== 1'b0) begin n_bad++; $display("FAIL u_divZero_clr: got %b need 0", divZero); end
    repeat (31) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL u_e31_flags: got busy=%b done=%b need 1/0", busy, done); end
    n_cmp++; if (dataOut !== {32'd123, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL u_hold_run: got %h need %h", dataOut, {32'd123, 32'hFFFF_FFFF}); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL u_e32_flags: got done=%b busy=%b need 1/0", done, busy); end
    n_cmp++; if (dataOut !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL u_100_7: got %h need %h", dataOut, {32'd2, 32'd14}); end
    n_cmp++; if (divZero !== 1'b0) begin n_bad++; $display("FAIL u_divZero: got %b need 0", divZero); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL u_done_pulse: got %b need 0", done); end
    do_div(DIVU_C, 32'd1000, 32'd33, r, lat, dz);
    n_cmp++; if (r !== {32'd10, 32'd30}) begin n_bad++; $display("FAIL u_1000_33: got %h need %h", r, {32'd10, 32'd30}); end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL u_latency: got %0d need 32", lat); end
    do_div(DIVU_C, 32'd5, 32'd9, r, lat, dz);
    n_cmp++; if (r !== {32'd5, 32'd0}) begin n_bad++; $display("FAIL u_5_9: got %h need %h", r, {32'd5, 32'd0}); end
  endtask

  task automatic test_max_dividend;
    logic [63:0] r; int lat; logic dz;
    do_div(DIVU_C, 32'hFFFF_FFFF, 32'd1, r, lat, dz);
    n_cmp++; if (r !== {32'd0, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL max_div1: got %h need %h", r, {32'd0, 32'hFFFF_FFFF}); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL max_div1_dz: got %b need 0", dz); end
    do_div(DIVU_C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, dz);
    n_cmp++; if (r !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL max_divmax: got %h need %h", r, {32'd0, 32'd1}); end
    do_div(DIVU_C, 32'hFFFF_FFFF, 32'h8000_0000, r, lat, dz);
    n_cmp++; if (r !== {32'h7FFF_FFFF, 32'd1}) begin n_bad++; $display("FAIL max_divhalf: got %h need %h", r, {32'h7FFF_FFFF, 32'd1}); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat; logic dz; logic seen;
    @(negedge clk);
    Signal = DIVU_C; dataA = 32'd100; dataB = 32'd7;
    @(posedge clk); #1;
    Signal = NOP_C;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dataOut !== 64'd0) begin n_bad++; $display("FAIL rm_dataOut: got %h need 0", dataOut); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || divZero !== 1'b0) begin n_bad++; $display("FAIL rm_flags: got busy=%b done=%b dz=%b need 0/0/0", busy, done, divZero); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rm_no_done: got activity=%b need 0", seen); end
    do_div(DIVU_C, 32'd9, 32'd3, r, lat, dz);
    n_cmp++; if (r !== {32'd0, 32'd3}) begin n_bad++; $display("FAIL rm_9_3: got %h need %h", r, {32'd0, 32'd3}); end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL rm_latency: got %0d need 32", lat); end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    Signal = DIVU_C; dataA = 32'd50; dataB = 32'd5;
    @(posedge clk); #1;
    Signal = NOP_C;
    repeat (4) @(posedge clk);
    #1;
    Signal = DIVU_C; dataA = 32'd8; dataB = 32'd2;
    @(posedge clk); #1;
    Signal = NOP_C;
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL swb_latency: got %0d need 32", lat); end
    n_cmp++; if (dataOut !== {32'd0, 32'd10}) begin n_bad++; $display("FAIL swb_result: got %h need %h", dataOut, {32'd0, 32'd10}); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL swb_ignored: got busy=%b need 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    Signal = DIVU_C; dataA = 32'd20; dataB = 32'd4;
    @(posedge clk); #1;
    dataA = 32'd30; dataB = 32'd5;
    repeat (32) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b1 || dataOut !== {32'd0, 32'd5}) begin n_bad++; $display("FAIL b2b_first: got done=%b out=%h need 1/%h", done, dataOut, {32'd0, 32'd5}); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_e33: got busy=%b done=%b need 0/0", busy, done); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_e34_start: got busy=%b need 1", busy); end
    Signal = NOP_C;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_latency: got %0d need 32", lat); end
    n_cmp++; if (dataOut !== {32'd0, 32'd6}) begin n_bad++; $display("FAIL b2b_second: got %h need %h", dataOut, {32'd0, 32'd6}); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
`ifdef DIVIDER_SIGNED_EN
    logic [63:0] r; int lat; logic dz;
    do_div(DIV_C, 32'hFFFF_FFF9, 32'd2, r, lat, dz);
    n_cmp++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL s_m7_2: got %h need %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL s_latency: got %0d need 32", lat); end
    do_div(DIV_C, 32'd7, 32'hFFFF_FFFE, r, lat, dz);
    n_cmp++; if (r !== {32'd1, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL s_7_m2: got %h need %h", r, {32'd1, 32'hFFFF_FFFD}); end
    do_div(DIV_C, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, dz);
    n_cmp++; if (r !== {32'd0, 32'h8000_0000} || dz !== 1'b0) begin n_bad++; $display("FAIL s_min_m1: got %h dz=%b need %h dz=0", r, dz, {32'd0, 32'h8000_0000}); end
    do_div(DIV_C, 32'hFFFF_FFF9, 32'd0, r, lat, dz);
    n_cmp++; if (r !== {32'hFFFF_FFF9, 32'hFFFF_FFFF} || dz !== 1'b1) begin n_bad++; $display("FAIL s_div0: got %h dz=%b need %h dz=1", r, dz, {32'hFFFF_FFF9, 32'hFFFF_FFFF}); end
`else
    logic seen;
    @(negedge clk);
    Signal = DIV_C; dataA = 32'hFFFF_FFF9; dataB = 32'd2;
    @(posedge clk); #1;
    Signal = NOP_C;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL s_ignored: got activity=%b need 0", seen); end
`endif
  endtask

  initial begin
    test_reset;
    test_div_zero;
    test_unsigned;
    test_max_dividend;
    test_reset_mid;
    test_start_while_busy;
    test_back_to_back;
    test_signed;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter DIVU, default 6'b011011, meaning Signal code that starts an unsigned divide.
REQ-002 SHALL have parameter DIV, default 6'b011010, meaning Signal code that starts a signed divide; used only with the signed macro.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port dataA, input, 32, dividend.
REQ-006 SHALL have port dataB, input, 32, divisor.
REQ-007 SHALL have port Signal, input, 6, operation code from ALU control.
REQ-008 SHALL have port dataOut, output, 64, {remainder[31:0], quotient[31:0]} (HI/LO).
REQ-009 SHALL have port busy, output, 1, high while a divide is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when dataOut holds a new result.
REQ-011 SHALL have port divZero, output, 1, high with done when the divisor was zero; holds until the next start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE, all transitions on rising clk.
REQ-013 In IDLE, Signal==DIVU at edge E0 SHALL latch dataA/dataB, clear partial remainder and step counter, enter RUN.
REQ-014 Signal values other than start codes in IDLE, and any Signal value in RUN or DONE, SHALL be ignored.
REQ-015 RUN SHALL perform one restoring step per edge: shift {rem,quot} left 1; if rem >= divisor, rem -= divisor and set quot[0]=1.
REQ-016 Partial remainder SHALL be 33 bits wide internally so the compare and subtract never overflow.
REQ-017 After exactly 32 steps (edges E1..E32), edge E32 SHALL load dataOut and enter DONE.
REQ-018 busy SHALL be high from after E0 through E32; done SHALL be high only in the cycle after E32.
REQ-019 DONE SHALL return to IDLE at the next edge; a start code present at that edge SHALL NOT be accepted (earliest restart is E34).
REQ-020 dataOut SHALL hold its last result until the next completion; it SHALL NOT change during RUN.
REQ-021 divisor==0 at E0 SHALL skip RUN: at E1 dataOut={dividend, 32'hFFFFFFFF}, divZero=1, done=1, then IDLE.
REQ-022 Unsigned results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-023 reset high at any edge SHALL force IDLE and set dataOut=0, busy=0, done=0, divZero=0.
REQ-024 Reset mid-RUN SHALL discard partial results; no done pulse SHALL follow.
REQ-025 reset SHALL take priority over a simultaneous start code.

Configuration
REQ-026 Macro DIVIDER_SIGNED_EN SHALL, when defined, enable acceptance of Signal==DIV as a signed start.
REQ-027 With the macro, signed start SHALL divide operand magnitudes, negate the quotient if signs differ, and give the remainder the dividend's sign.
REQ-028 With the macro, 32'h80000000 / -1 SHALL give quotient 32'h80000000, remainder 0, divZero=0.
REQ-029 With the macro, a signed divide by zero SHALL give quotient 32'hFFFFFFFF, remainder = dividend, divZero=1.
REQ-030 Without the macro, Signal==DIV SHALL be ignored like any non-start code and no sign logic SHALL be synthesized.
REQ-031 Latency SHALL be identical (32 steps) in both builds.

Verification
REQ-032 Test unsigned divide: DIVU, A=100, B=7 -> done one cycle after E32 with dataOut={32'd2, 32'd14}, divZero=0.
REQ-033 Test maximum dividend: DIVU, A=32'hFFFFFFFF, B=1 -> dataOut={0, 32'hFFFFFFFF}; B=32'hFFFFFFFF gives {0, 1}.
REQ-034 Test divide by zero: DIVU, A=123, B=0 -> at E1 done=1, divZero=1, dataOut={32'd123, 32'hFFFFFFFF}, busy never high.
REQ-035 Test reset mid-operation: start DIVU 100/7, assert reset at E10 -> next cycle all outputs 0, no done; a new 9/3 start then yields {0, 3}.
REQ-036 Test start while busy: start DIVU 50/5, drive DIVU 8/2 at E5 -> result {0, 10}; second request ignored.
REQ-037 Test signed divide (macro defined): DIV, A=-7, B=2 -> {32'hFFFFFFFF, 32'hFFFFFFFD}; without macro, same stimulus -> busy stays 0, no done.
